// File: rtl/mcu_bus_receiver.sv
// MCU parallel-bus front end: strobe synchroniser, command/data split,
// multi-beat word assembly and a show-ahead data FIFO with busy/error flags.
module mcu_bus_receiver #(
  parameter int BUS_WIDTH   = 8,
  parameter int WORD_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int BUSY_MARGIN = 2,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  system_clock,
  input  logic                  system_reset,
  input  logic                  bus_clock,
  input  logic [BUS_WIDTH-1:0]  signal_input,
  input  logic                  signal_command_data_input,
  output logic                  signal_command_data_output,
  output logic [BUS_WIDTH-1:0]  command,
  output logic                  command_valid,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow,
  output logic                  framing_error,
  input  logic                  clear_errors
);

  localparam int BEATS = WORD_WIDTH / BUS_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic                  sync_s1_r, sync_s2_r, sync_s3_r;
  logic [CNT_W-1:0]      beat_count_r;
  logic [WORD_WIDTH-1:0] asm_r;
  logic [WORD_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]      level_r;
  logic [BUS_WIDTH-1:0]  command_r;
  logic                  command_valid_r;
  logic                  busy_r, overflow_r, framing_r;

  logic                  beat_s, cmd_beat_s, data_beat_s, last_beat_s;
  logic                  push_s, pop_s, full_s, push_ok_s;
  logic                  ovf_set_s, frm_set_s, busy_nxt_s;
  logic [LVL_W-1:0]      level_nxt_s;
  logic [WORD_WIDTH-1:0] word_s;

  // Beat detection, FIFO handshakes and next occupancy.
  always_comb begin
    beat_s      = sync_s2_r & ~sync_s3_r;
    cmd_beat_s  = beat_s & ~signal_command_data_input;
    data_beat_s = beat_s & signal_command_data_input;
    last_beat_s = (beat_count_r == CNT_W'(BEATS - 1));
    push_s      = data_beat_s & last_beat_s;
    pop_s       = (level_r != LVL_W'(0)) & data_ready;
    full_s      = (level_r == LVL_W'(FIFO_DEPTH));
    push_ok_s   = push_s & (~full_s | pop_s);
    ovf_set_s   = push_s & full_s & ~pop_s;
    frm_set_s   = cmd_beat_s & (beat_count_r != CNT_W'(0));
    word_s      = asm_r;
    word_s[int'(beat_count_r) * BUS_WIDTH +: BUS_WIDTH] = signal_input;
    case ({push_ok_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
    busy_nxt_s = ((FIFO_DEPTH - int'(level_nxt_s)) <= BUSY_MARGIN);
  end

  // Control state: synchroniser, assembly, pointers, flags.
  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      sync_s1_r       <= 1'b0;
      sync_s2_r       <= 1'b0;
      sync_s3_r       <= 1'b0;
      beat_count_r    <= CNT_W'(0);
      asm_r           <= {WORD_WIDTH{1'b0}};
      wr_ptr_r        <= PTR_W'(0);
      rd_ptr_r        <= PTR_W'(0);
      level_r         <= LVL_W'(0);
      command_r       <= {BUS_WIDTH{1'b0}};
      command_valid_r <= 1'b0;
      busy_r          <= 1'b0;
      overflow_r      <= 1'b0;
      framing_r       <= 1'b0;
    end else begin
      sync_s1_r       <= bus_clock;
      sync_s2_r       <= sync_s1_r;
      sync_s3_r       <= sync_s2_r;
      command_valid_r <= 1'b0;
      if (cmd_beat_s) begin
        // A command mid-word abandons the partial word.
        command_r       <= signal_input;
        command_valid_r <= 1'b1;
        beat_count_r    <= CNT_W'(0);
      end else if (data_beat_s) begin
        asm_r        <= word_s;
        beat_count_r <= last_beat_s ? CNT_W'(0) : beat_count_r + CNT_W'(1);
      end
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r    <= level_nxt_s;
      busy_r     <= busy_nxt_s;
      overflow_r <= ovf_set_s | (overflow_r & ~clear_errors);
      framing_r  <= frm_set_s | (framing_r & ~clear_errors);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge system_clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= word_s;
  end

  assign data_valid                 = (level_r != LVL_W'(0));
  assign data_out                   = data_valid ? mem_r[rd_ptr_r] : {WORD_WIDTH{1'b0}};
  assign fifo_level                 = level_r;
  assign command                    = command_r;
  assign command_valid              = command_valid_r;
  assign overflow                   = overflow_r;
  assign framing_error              = framing_r;
  assign signal_command_data_output = busy_r;

endmodule

// File: tb/tb_mcu_bus_receiver.sv
// Directed self-checking bench for mcu_bus_receiver (8-bit beats, 16-bit words, 4-deep FIFO).
module tb_mcu_bus_receiver;

  logic        system_clock = 1'b0;
  logic        system_reset = 1'b1;
  logic        bus_clock = 1'b0;
  logic [7:0]  signal_input = 8'h00;
  logic        signal_command_data_input = 1'b0;
  logic        busy;
  logic [7:0]  command;
  logic        command_valid;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        framing_error;
  logic        clear_errors = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  mcu_bus_receiver #(
    .BUS_WIDTH(8), .WORD_WIDTH(16), .FIFO_DEPTH(4), .BUSY_MARGIN(1)
  ) dut (
    .system_clock(system_clock),
    .system_reset(system_reset),
    .bus_clock(bus_clock),
    .signal_input(signal_input),
    .signal_command_data_input(signal_command_data_input),
    .signal_command_data_output(busy),
    .command(command),
    .command_valid(command_valid),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .framing_error(framing_error),
    .clear_errors(clear_errors)
  );

  always #5 system_clock = ~system_clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One strobed beat; returns on a falling edge well after capture.
  task automatic send_beat(input logic sel, input logic [7:0] v);
    @(negedge system_clock);
    signal_input = v;
    signal_command_data_input = sel;
    bus_clock = 1'b1;
    repeat (4) @(negedge system_clock);
    bus_clock = 1'b0;
    repeat (3) @(negedge system_clock);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_beat(1'b1, w[7:0]);
    send_beat(1'b1, w[15:8]);
  endtask

  task automatic pop_one();
    data_ready = 1'b1;
    @(negedge system_clock);
    data_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge system_clock);
    clear_errors = 1'b1;
    @(negedge system_clock);
    clear_errors = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_w [4];

    // Reset and idle
    repeat (2) @(negedge system_clock);
    system_reset = 1'b0;
    repeat (10) @(negedge system_clock);
    check_eq("rst_command", 32'(command), 32'h0);
    check_eq("rst_cvalid", 32'(command_valid), 32'h0);
    check_eq("rst_data_out", 32'(data_out), 32'h0);
    check_eq("rst_dvalid", 32'(data_valid), 32'h0);
    check_eq("rst_level", 32'(fifo_level), 32'h0);
    check_eq("rst_flags", 32'({overflow, framing_error, busy}), 32'h0);

    // Command beat latency and one-cycle valid
    @(negedge system_clock);
    signal_input = 8'hA5;
    signal_command_data_input = 1'b0;
    bus_clock = 1'b1;
    @(posedge system_clock); #1;
    check_eq("cmd_k_valid", 32'(command_valid), 32'h0);
    @(posedge system_clock); #1;
    check_eq("cmd_k1_cmd", 32'(command), 32'h0);
    check_eq("cmd_k1_valid", 32'(command_valid), 32'h0);
    @(posedge system_clock); #1;
    check_eq("cmd_k2_cmd", 32'(command), 32'hA5);
    check_eq("cmd_k2_valid", 32'(command_valid), 32'h1);
    @(posedge system_clock); #1;
    check_eq("cmd_k3_valid", 32'(command_valid), 32'h0);
    @(negedge system_clock);
    bus_clock = 1'b0;
    repeat (3) @(negedge system_clock);
    check_eq("cmd_fifo_level", 32'(fifo_level), 32'h0);

    // Two-beat word, LSB first
    send_word(16'h1234);
    check_eq("w1_data", 32'(data_out), 32'h1234);
    check_eq("w1_valid", 32'(data_valid), 32'h1);
    check_eq("w1_level", 32'(fifo_level), 32'h1);
    check_eq("w1_busy", 32'(busy), 32'h0);
    pop_one();
    check_eq("w1_pop_level", 32'(fifo_level), 32'h0);

    // Framing error: command interrupts a partial word
    send_beat(1'b1, 8'h77);
    send_beat(1'b0, 8'h01);
    send_word(16'hABCD);
    check_eq("frm_flag", 32'(framing_error), 32'h1);
    check_eq("frm_command", 32'(command), 32'h01);
    check_eq("frm_level", 32'(fifo_level), 32'h1);
    check_eq("frm_data", 32'(data_out), 32'hABCD);
    pop_one();
    pulse_clear();
    check_eq("frm_cleared", 32'(framing_error), 32'h0);

    // Fill past full, busy threshold and overflow
    send_word(16'h0001);
    check_eq("fill1_busy", 32'(busy), 32'h0);
    send_word(16'h0002);
    check_eq("fill2_busy", 32'(busy), 32'h0);
    send_word(16'h0003);
    check_eq("fill3_level", 32'(fifo_level), 32'h3);
    check_eq("fill3_busy", 32'(busy), 32'h1);
    send_word(16'h0004);
    check_eq("fill4_ovf", 32'(overflow), 32'h0);
    send_word(16'h0005);
    check_eq("fill5_level", 32'(fifo_level), 32'h4);
    check_eq("fill5_ovf", 32'(overflow), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check_eq($sformatf("drain_%0d", i), 32'(data_out), 32'(i));
      pop_one();
    end
    check_eq("drain_level", 32'(fifo_level), 32'h0);
    check_eq("drain_valid", 32'(data_valid), 32'h0);
    check_eq("drain_busy", 32'(busy), 32'h0);
    pulse_clear();
    check_eq("ovf_cleared", 32'(overflow), 32'h0);

    // Full FIFO: completing word coincides with a pop
    send_word(16'h1111);
    send_word(16'h2222);
    send_word(16'h3333);
    send_word(16'h4444);
    check_eq("full_level", 32'(fifo_level), 32'h4);
    send_beat(1'b1, 8'h55);
    @(negedge system_clock);
    signal_input = 8'h55;
    signal_command_data_input = 1'b1;
    bus_clock = 1'b1;
    @(negedge system_clock);
    @(negedge system_clock);
    data_ready = 1'b1;
    @(negedge system_clock);
    data_ready = 1'b0;
    check_eq("pp_ovf", 32'(overflow), 32'h0);
    check_eq("pp_level", 32'(fifo_level), 32'h4);
    check_eq("pp_busy", 32'(busy), 32'h1);
    bus_clock = 1'b0;
    repeat (3) @(negedge system_clock);
    exp_w[0] = 16'h2222;
    exp_w[1] = 16'h3333;
    exp_w[2] = 16'h4444;
    exp_w[3] = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("pp_drain_%0d", i), 32'(data_out), 32'(exp_w[i]));
      pop_one();
    end

    // Framing error then clear
    send_beat(1'b1, 8'h42);
    send_beat(1'b0, 8'h3C);
    check_eq("frm2_flag", 32'(framing_error), 32'h1);
    pulse_clear();
    check_eq("frm2_cleared", 32'({overflow, framing_error}), 32'h0);

    // Reset mid-word with a non-empty FIFO
    send_word(16'h0102);
    send_beat(1'b1, 8'h99);
    @(negedge system_clock);
    system_reset = 1'b1;
    @(negedge system_clock);
    system_reset = 1'b0;
    @(negedge system_clock);
    check_eq("mrst_level", 32'(fifo_level), 32'h0);
    check_eq("mrst_valid", 32'(data_valid), 32'h0);
    check_eq("mrst_data", 32'(data_out), 32'h0);
    check_eq("mrst_command", 32'(command), 32'h0);
    send_word(16'h1122);
    check_eq("mrst_word", 32'(data_out), 32'h1122);
    check_eq("mrst_word_level", 32'(fifo_level), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
